seq_multiplier_8x8: RTL

Sequential 8x8 unsigned shift-and-add multiplier controller that drives an external `eight_bit_full_adder` instance and consumes its sum and carry. It owns the operand, partial-product and iteration registers. It produces a 16-bit product after a fixed 8-iteration sequence under a start/busy/done handshake. The adder stays purely combinational; this block supplies all sequencing around it.

---
 rtl/seq_multiplier_8x8.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_multiplier_8x8.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_8x8
// Description : 8x8 unsigned shift-and-add multiplier controller wrapped
//               around an external combinational 8-bit adder.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier_8x8 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  mcand,
    input  logic [7:0]  mplier,
    input  logic [7:0]  add_sum,
    input  logic        add_cout,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_ITER = 3'd7;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_m;
    logic [7:0]  r_q;
    logic [7:0]  r_a;
    logic [2:0]  r_cnt;
    logic [15:0] r_product;
    logic        w_last_iter;

    assign w_last_iter = (r_cnt == c_LAST_ITER);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last_iter) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The adder result is split across A and Q: the 9-bit sum shifts right by
    // one, with its LSB entering the top of Q as a new product bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_m       <= 8'h00;
            r_q       <= 8'h00;
            r_a       <= 8'h00;
            r_cnt     <= 3'd0;
            r_product <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m   <= mcand;
                        r_q   <= mplier;
                        r_a   <= 8'h00;
                        r_cnt <= 3'd0;
                    end
                end
                S_CALC: begin
                    r_a   <= {add_cout, add_sum[7:1]};
                    r_q   <= {add_sum[0], r_q[7:1]};
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last_iter) begin
                        r_product <= {add_cout, add_sum, r_q[7:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign add_a   = r_a;
    assign add_b   = ((r_state == S_CALC) && r_q[0]) ? r_m : 8'h00;
    assign add_cin = 1'b0;
    assign busy    = (r_state == S_CALC);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule
`default_nettype wire
